// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cpu_pkg
// Purpose : Shared sequencer states and 6502 group-01 opcode field encodings
//           (cc group, bbb addressing mode, aaa operation).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Bus-cycle states of the address sequencer.
  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_OPER_LO = 3'd1,
    ST_OPER_HI = 3'd2,
    ST_ZP_IDX  = 3'd3,
    ST_ABS_FIX = 3'd4,
    ST_EXEC    = 3'd5,
    ST_IMPL    = 3'd6
  } state_t;

  // cc field (opcode bits [1:0]): instruction group.
  localparam logic [1:0] CC_GRP00 = 2'b00;
  localparam logic [1:0] CC_GRP01 = 2'b01;
  localparam logic [1:0] CC_GRP10 = 2'b10;

  // bbb field (opcode bits [4:2]): group-01 addressing mode.
  localparam logic [2:0] MODE_IZX = 3'b000;
  localparam logic [2:0] MODE_ZP  = 3'b001;
  localparam logic [2:0] MODE_IMM = 3'b010;
  localparam logic [2:0] MODE_ABS = 3'b011;
  localparam logic [2:0] MODE_IZY = 3'b100;
  localparam logic [2:0] MODE_ZPX = 3'b101;
  localparam logic [2:0] MODE_ABY = 3'b110;
  localparam logic [2:0] MODE_ABX = 3'b111;

  // aaa field (opcode bits [7:5]): group-01 operation.
  localparam logic [2:0] OP_ORA = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_EOR = 3'b010;
  localparam logic [2:0] OP_ADC = 3'b011;
  localparam logic [2:0] OP_STA = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_SBC = 3'b111;

  // Reset values.
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h8000;
  localparam logic [7:0]  IR_RESET         = 8'hEA;  // NOP

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_addr_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cpu_addr_sequencer
// Purpose : Owns PC, IR and the bus address; sequences fetch/operand cycles
//           for group-01 instructions in six addressing modes, with a
//           page-crossing penalty and a RDY-style stall. Emits operand-valid
//           and write strobes for the external execute datapath.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module cpu_addr_sequencer
  import cpu_pkg::*;
#(
  parameter int          ADDR_W       = 16,
  parameter logic [15:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          PAGE_PENALTY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic [7:0]        d_in,
  input  logic [7:0]        x_idx,
  input  logic [7:0]        y_idx,
  output logic [ADDR_W-1:0] addr,
  output logic              sync,
  output logic              write,
  output logic              op_valid,
  output logic [7:0]        ir,
  output logic [ADDR_W-1:0] pc,
  output logic              unsup
);

  localparam int                HI_W   = ADDR_W - 8;
  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] PC_ONE = 1;
  localparam logic [HI_W-1:0]   HI_ONE = 1;
  localparam logic [HI_W-1:0]   HI_ZERO = '0;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [7:0]         ir_q, ir_d;
  logic [7:0]         lo_q, lo_d;
  logic [HI_W-1:0]    hi_q, hi_d;
  logic [ADDR_W-1:0]  eff_q, eff_d;
  logic [8:0]         sum_q, sum_d;

  // Ungated strobes; ready masks them at the port.
  logic               write_raw;
  logic               op_valid_raw;
  logic               unsup_raw;

  // Decoded fields of the latched opcode.
  logic [2:0]         mode;
  logic               is_sta;
  logic [7:0]         idx;
  logic [8:0]         sum;
  logic [7:0]         zp_sum;
  logic [HI_W-1:0]    d_hi;
  logic               fast_path;

  // Index selection and the single 9-bit low-byte adder.
  always_comb begin
    mode   = ir_q[4:2];
    is_sta = (ir_q[7:5] == OP_STA);
    if (mode == MODE_ABX) begin
      idx = x_idx;
    end else if (mode == MODE_ABY) begin
      idx = y_idx;
    end else begin
      idx = 8'h00;
    end
    sum       = {1'b0, lo_q} + {1'b0, idx};
    zp_sum    = lo_q + x_idx;              // zero page wraps, no carry out
    d_hi      = d_in[HI_W-1:0];            // high byte truncated to the bus
    // Indexed loads skip ABS_FIX only when no carry and penalty is conditional.
    fast_path = !sum[8] && !is_sta && (PAGE_PENALTY != 0);
  end

  // Next-state, register updates and bus outputs for the current cycle.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    eff_d        = eff_q;
    sum_d        = sum_q;
    addr         = pc_q;
    sync         = 1'b0;
    write_raw    = 1'b0;
    op_valid_raw = 1'b0;
    unsup_raw    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        sync = 1'b1;
        ir_d = d_in;
        pc_d = pc_q + PC_ONE;
        if (d_in[1:0] != CC_GRP01) begin
          state_d = ST_IMPL;
        end else begin
          state_d = ST_OPER_LO;
        end
      end

      ST_OPER_LO: begin
        pc_d = pc_q + PC_ONE;
        lo_d = d_in;
        case (mode)
          MODE_IMM: begin
            if (is_sta) begin
              unsup_raw = 1'b1;      // STA #imm has no meaning
            end else begin
              op_valid_raw = 1'b1;
            end
            state_d = ST_FETCH;
          end
          MODE_IZX, MODE_IZY: begin
            unsup_raw = 1'b1;
            state_d   = ST_FETCH;
          end
          MODE_ZP: begin
            eff_d   = {HI_ZERO, d_in};
            state_d = ST_EXEC;
          end
          MODE_ZPX: begin
            state_d = ST_ZP_IDX;
          end
          default: begin
            state_d = ST_OPER_HI;
          end
        endcase
      end

      ST_ZP_IDX: begin
        addr    = {HI_ZERO, lo_q};   // dummy read at the unindexed address
        eff_d   = {HI_ZERO, zp_sum};
        state_d = ST_EXEC;
      end

      ST_OPER_HI: begin
        pc_d  = pc_q + PC_ONE;
        hi_d  = d_hi;
        sum_d = sum;
        if (mode == MODE_ABS) begin
          eff_d   = {d_hi, lo_q};
          state_d = ST_EXEC;
        end else if (fast_path) begin
          eff_d   = {d_hi, sum[7:0]};
          state_d = ST_EXEC;
        end else begin
          state_d = ST_ABS_FIX;
        end
      end

      ST_ABS_FIX: begin
        addr    = {hi_q, sum_q[7:0]};  // dummy read before high-byte fix-up
        eff_d   = {hi_q + (sum_q[8] ? HI_ONE : HI_ZERO), sum_q[7:0]};
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        addr = eff_q;
        if (is_sta) begin
          write_raw = 1'b1;
        end else begin
          op_valid_raw = 1'b1;
        end
        state_d = ST_FETCH;
      end

      ST_IMPL: begin
        unsup_raw = 1'b1;
        state_d   = ST_FETCH;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers; everything holds while ready is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RST_PC;
      ir_q    <= IR_RESET;
      lo_q    <= 8'h00;
      hi_q    <= HI_ZERO;
      eff_q   <= '0;
      sum_q   <= 9'h000;
    end else if (ready) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      eff_q   <= eff_d;
      sum_q   <= sum_d;
    end
  end

  // A stalled cycle repeats, so masking strobes with ready makes them fire
  // exactly once, on the cycle that actually completes.
  assign write    = write_raw & ready;
  assign op_valid = op_valid_raw & ready;
  assign unsup    = unsup_raw & ready;
  assign ir       = ir_q;
  assign pc       = pc_q;

endmodule : cpu_addr_sequencer
`default_nettype wire
